// File: rtl/keypad_opcode_encoder.sv
// rtl/keypad_opcode_encoder.sv - keypad synchroniser, debouncer, priority opcode encoder with valid/ready output
// Optional auto-repeat while a key set is held: define KEYPAD_REPEAT_EN.
module keypad_opcode_encoder #(
    parameter int                  NUM_KEYS        = 8,
    parameter int                  OUT_W           = 4,
    parameter int                  DEBOUNCE_CYCLES = 4,
    parameter int                  REPEAT_CYCLES   = 16,
    parameter logic [NUM_KEYS-1:0] OP_MASK         = NUM_KEYS'(8'b0000_0011),
    parameter logic [NUM_KEYS-1:0] RESULT_MASK     = NUM_KEYS'(8'b0000_0011),
    parameter logic [NUM_KEYS-1:0] ENTER_MASK      = NUM_KEYS'(8'b1000_0000)
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic [NUM_KEYS-1:0] in,
    input  logic                ready,
    output logic                valid,
    output logic [OUT_W-1:0]    out,
    output logic                is_op,
    output logic                is_result,
    output logic                is_enter,
    output logic                overflow
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Reject parameter sets the encoder cannot represent.
    if (NUM_KEYS < 2 || NUM_KEYS > 15 || (1 << OUT_W) <= NUM_KEYS ||
        DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_params
        $error("keypad_opcode_encoder: invalid parameters");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_HELD,
        S_RELEASE
    } state_t;

    state_t              state, state_nxt;
    logic [NUM_KEYS-1:0] meta, sync;
    logic [NUM_KEYS-1:0] snap, snap_nxt;
    logic [CNT_W-1:0]    cnt, cnt_nxt;
    logic                emit;
    logic [OUT_W-1:0]    enc_idx;
    logic                enc_op, enc_res, enc_ent;
    logic                sync_zero, sync_same;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    localparam logic [REP_W-1:0] REP_ONE  = REP_W'(1);
    logic [REP_W-1:0] rep, rep_nxt;
`endif

    assign sync_zero = (sync == '0);
    assign sync_same = (sync == snap);

    // First synchroniser stage keeps sampling through reset so a key held
    // across reset reaches sync one edge after reset releases.
    always_ff @(posedge clk) begin
        meta <= in;
    end

    // Second synchroniser stage, FSM state and debounce datapath registers.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            sync  <= '0;
            state <= S_IDLE;
            snap  <= '0;
            cnt   <= '0;
`ifdef KEYPAD_REPEAT_EN
            rep   <= '0;
`endif
        end else begin
            sync  <= meta;
            state <= state_nxt;
            snap  <= snap_nxt;
            cnt   <= cnt_nxt;
`ifdef KEYPAD_REPEAT_EN
            rep   <= rep_nxt;
`endif
        end
    end

    // Next-state: press debounce, hold, release debounce.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:     if (!sync_zero) state_nxt = S_DEBOUNCE;
            S_DEBOUNCE: begin
                if (sync_zero)                      state_nxt = S_IDLE;
                else if (sync_same && cnt == CNT_MAX) state_nxt = S_HELD;
            end
            S_HELD:     if (sync_zero) state_nxt = S_RELEASE;
            S_RELEASE: begin
                if (!sync_zero)          state_nxt = S_HELD;
                else if (cnt == CNT_MAX) state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: snapshot/counter updates and the emit strobe.
    always_comb begin
        snap_nxt = snap;
        cnt_nxt  = cnt;
        emit     = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_nxt  = rep;
`endif
        unique case (state)
            S_IDLE: begin
                if (!sync_zero) begin
                    snap_nxt = sync;
                    cnt_nxt  = CNT_ONE;
                end
            end
            S_DEBOUNCE: begin
                if (!sync_zero) begin
                    if (!sync_same) begin
                        snap_nxt = sync;
                        cnt_nxt  = CNT_ONE;
                    end else if (cnt == CNT_MAX) begin
                        emit = 1'b1;
`ifdef KEYPAD_REPEAT_EN
                        rep_nxt = '0;
`endif
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
            end
            S_HELD: begin
                if (sync_zero) begin
                    cnt_nxt = CNT_ONE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (sync_same) begin
                    if (rep == REP_LAST) begin
                        emit    = 1'b1;
                        rep_nxt = '0;
                    end else begin
                        rep_nxt = rep + REP_ONE;
                    end
                end else begin
                    rep_nxt = '0;
                end
`endif
            end
            S_RELEASE: begin
                if (!sync_zero) begin
`ifdef KEYPAD_REPEAT_EN
                    rep_nxt = '0;
`endif
                end else if (cnt != CNT_MAX) begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            default: begin
                snap_nxt = '0;
                cnt_nxt  = '0;
            end
        endcase
    end

    // Priority encoder: lowest set bit of the snapshot wins.
    always_comb begin
        enc_idx = '0;
        enc_op  = 1'b0;
        enc_res = 1'b0;
        enc_ent = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (snap[i]) begin
                enc_idx = OUT_W'(i);
                enc_op  = OP_MASK[i];
                enc_res = RESULT_MASK[i];
                enc_ent = ENTER_MASK[i];
            end
        end
    end

    // One-entry output register; an event arriving while full and stalled is dropped.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            valid     <= 1'b0;
            out       <= '0;
            is_op     <= 1'b0;
            is_result <= 1'b0;
            is_enter  <= 1'b0;
            overflow  <= 1'b0;
        end else if (emit) begin
            if (!valid || ready) begin
                valid     <= 1'b1;
                out       <= enc_idx + OUT_W'(1);
                is_op     <= enc_op;
                is_result <= enc_res;
                is_enter  <= enc_ent;
            end else begin
                overflow  <= 1'b1;
            end
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_keypad_opcode_encoder.sv
// tb/tb_keypad_opcode_encoder.sv - self-checking bench for keypad_opcode_encoder
module tb_keypad_opcode_encoder;

    localparam int D = 4;
    localparam logic [7:0] OPM  = 8'b0000_0011;
    localparam logic [7:0] RESM = 8'b0000_0011;
    localparam logic [7:0] ENTM = 8'b1000_0000;

    logic       clk = 1'b0;
    logic       nrst;
    logic [7:0] in_v;
    logic       ready;
    logic       valid;
    logic [3:0] out;
    logic       is_op, is_result, is_enter, overflow;

    int checks = 0;
    int errors = 0;

    // Run-length reference model state.
    logic [7:0] m_d1, m_d2, m_prev;
    bit         m_armed;
    int         m_zrun, m_run;
    logic       m_valid, m_op, m_res, m_ent, m_ov;
    logic [3:0] m_out;

    always #5 clk = ~clk;

    keypad_opcode_encoder #(
        .NUM_KEYS(8), .OUT_W(4), .DEBOUNCE_CYCLES(D), .REPEAT_CYCLES(16),
        .OP_MASK(OPM), .RESULT_MASK(RESM), .ENTER_MASK(ENTM)
    ) dut (
        .clk(clk), .nrst(nrst), .in(in_v), .ready(ready),
        .valid(valid), .out(out), .is_op(is_op), .is_result(is_result),
        .is_enter(is_enter), .overflow(overflow)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // A press emits once its value has been seen on D+1 consecutive synchronised
    // samples, provided at least D+1 zero samples came since the last emission.
    task automatic model_edge(input logic [7:0] v, input logic r, input logic rst_n);
        logic [7:0] s;
        bit em;
        int idx;
        em = 0;
        if (!rst_n) begin
            m_d2 = '0; m_d1 = v; m_prev = '0;
            m_armed = 1; m_zrun = 0; m_run = 0;
            m_valid = 0; m_out = '0; m_op = 0; m_res = 0; m_ent = 0; m_ov = 0;
            return;
        end
        s = m_d2; m_d2 = m_d1; m_d1 = v;
        if (s == 0) begin
            m_zrun++; m_run = 0;
            if (m_zrun > D) m_armed = 1;
        end else begin
            m_zrun = 0;
            m_run = (s == m_prev) ? m_run + 1 : 1;
            if (m_armed && m_run == D + 1) begin
                em = 1; m_armed = 0;
            end
        end
        m_prev = s;
        if (em) begin
            if (!m_valid || r) begin
                idx = 0;
                while (!s[idx]) idx++;
                m_valid = 1; m_out = 4'(idx + 1);
                m_op = OPM[idx]; m_res = RESM[idx]; m_ent = ENTM[idx];
            end else begin
                m_ov = 1;
            end
        end else if (m_valid && r) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input logic [7:0] v, input logic r, input logic rst_n);
        @(negedge clk);
        in_v = v; ready = r; nrst = rst_n;
        @(posedge clk);
        model_edge(v, r, rst_n);
        #1;
    endtask

    task automatic do_reset();
        step(8'h00, 1'b0, 1'b0);
        step(8'h00, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic [7:0] key;
        int         e_out;
        bit         e_op, e_res, e_ent;
    } vec_t;

    vec_t tbl[5];
    bit   saw;

    initial begin
        tbl[0] = '{8'b0000_0100, 3, 0, 0, 0};
        tbl[1] = '{8'b1000_0010, 2, 1, 1, 0};
        tbl[2] = '{8'b1000_0000, 8, 0, 0, 1};
        tbl[3] = '{8'b0000_0001, 1, 1, 1, 0};
        tbl[4] = '{8'b0101_0000, 5, 0, 0, 0};

        in_v = '0; ready = 1'b0; nrst = 1'b0;
        do_reset();
        chk("reset_valid", valid, 0);
        chk("reset_out", out, 0);
        chk("reset_overflow", overflow, 0);

        // Table: hold each key set with ready low; exactly one event, no drop.
        for (int t = 0; t < 5; t++) begin
            do_reset();
            for (int k = 0; k < 20; k++) step(tbl[t].key, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_valid", t), valid, 1);
            chk($sformatf("tbl%0d_out", t), out, tbl[t].e_out);
            chk($sformatf("tbl%0d_op", t), is_op, tbl[t].e_op);
            chk($sformatf("tbl%0d_res", t), is_result, tbl[t].e_res);
            chk($sformatf("tbl%0d_ent", t), is_enter, tbl[t].e_ent);
            chk($sformatf("tbl%0d_ovf", t), overflow, 0);
        end

        // Latency: valid only after edge 6, consumed on edge 7.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step(8'b0000_0100, 1'b1, 1'b1);
            chk($sformatf("lat_valid_e%0d", k), valid, (k == 6) ? 1 : 0);
            if (k == 6) begin
                chk("lat_out", out, 3);
                chk("lat_flags", {is_op, is_result, is_enter}, 0);
            end
        end

        // Glitch shorter than the debounce window.
        do_reset();
        saw = 0;
        for (int k = 0; k < 18; k++) begin
            step((k < 3) ? 8'h01 : 8'h00, 1'b1, 1'b1);
            if (valid) saw = 1;
        end
        chk("glitch_no_valid", saw, 0);

        // Backpressure: second press dropped, overflow sticky.
        do_reset();
        for (int k = 0; k < 10; k++) step(8'h01, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(8'h00, 1'b0, 1'b1);
        chk("ovf_pre", overflow, 0);
        for (int k = 0; k < 10; k++) step(8'h01, 1'b0, 1'b1);
        chk("ovf_valid", valid, 1);
        chk("ovf_out", out, 1);
        chk("ovf_flag", overflow, 1);
        step(8'h00, 1'b1, 1'b1);
        chk("ovf_drain_valid", valid, 0);
        chk("ovf_drain_out", out, 1);
        chk("ovf_sticky", overflow, 1);

        // Reset mid-HELD with key 7 still pressed.
        do_reset();
        for (int k = 0; k < 10; k++) step(8'h80, 1'b0, 1'b1);
        chk("rh_pre_out", out, 8);
        step(8'h80, 1'b0, 1'b0);
        chk("rh_valid", valid, 0);
        chk("rh_out", out, 0);
        chk("rh_flags", {is_op, is_result, is_enter, overflow}, 0);
        for (int k = 1; k <= 6; k++) begin
            step(8'h80, 1'b0, 1'b1);
            chk($sformatf("rh_valid_e%0d", k), valid, (k == 6) ? 1 : 0);
        end
        chk("rh_event_out", out, 8);
        chk("rh_event_ent", is_enter, 1);
        chk("rh_event_op", is_op, 0);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat every 16 cycles while key 1 stays held.
        do_reset();
        for (int k = 0; k < 60; k++) begin
            step(8'h02, 1'b1, 1'b1);
            chk($sformatf("rep_valid_e%0d", k), valid,
                (k == 6 || k == 22 || k == 38 || k == 54) ? 1 : 0);
            if (valid) chk($sformatf("rep_out_e%0d", k), out, 2);
        end
`else
        // Randomised key activity and backpressure against the run-length model.
        do_reset();
        for (int b = 0; b < 400; b++) begin
            logic [7:0] v;
            int len;
            logic rst_n;
            case ($urandom_range(0, 3))
                0:       v = 8'h00;
                1:       v = 8'h01 << $urandom_range(0, 7);
                2:       v = 8'($urandom_range(1, 255));
                default: v = (b % 2) ? 8'h00 : 8'h80;
            endcase
            len = $urandom_range(1, 12);
            rst_n = ($urandom_range(0, 99) != 0);
            for (int k = 0; k < len; k++) begin
                step(v, ($urandom_range(0, 3) != 0), (k == 0) ? rst_n : 1'b1);
                chk("rnd_valid", valid, m_valid);
                chk("rnd_ovf", overflow, m_ov);
                if (m_valid) begin
                    chk("rnd_out", out, m_out);
                    chk("rnd_flags", {is_op, is_result, is_enter}, {m_op, m_res, m_ent});
                end
            end
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
